// File: rtl/ram_rd_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ram_rd_arbiter
// Purpose  : Round-robin sharing of a 1R1W RAM read port between NB_RD
//            requesters; writes have priority and same-cycle collisions are
//            either stalled or forwarded.
// Revision : 1.0 - initial release
// ============================================================================
module ram_rd_arbiter #(
  parameter  int WIDTH             = 32,
  parameter  int DEPTH             = 1024,
  parameter  int NB_RD             = 2,
  parameter  int RAM_LATENCY       = 1,
  parameter  int RD_WR_ACCESS_TYPE = 0,
  localparam int AW                = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  a_rst_n,
  input  logic                  wr_en,
  input  logic [AW-1:0]         wr_add,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic [NB_RD-1:0]      rd_req_vld,
  output logic [NB_RD-1:0]      rd_req_rdy,
  input  logic [NB_RD*AW-1:0]   rd_req_add,
  output logic [NB_RD-1:0]      rd_data_vld,
  output logic [WIDTH-1:0]      rd_data,
  output logic                  ram_wr_en,
  output logic [AW-1:0]         ram_wr_add,
  output logic [WIDTH-1:0]      ram_wr_data,
  output logic                  ram_rd_en,
  output logic [AW-1:0]         ram_rd_add,
  input  logic [WIDTH-1:0]      ram_rd_data
);

  // Access-type encoding shared with ram_wrapper_pkg.
  localparam int c_ACCESS_CONFLICT = 0;
  localparam int c_ACCESS_READ_NEW = 1;
  localparam int c_ACCESS_READ_OLD = 2;
  localparam int c_PW              = (NB_RD > 1) ? $clog2(NB_RD) : 1;

  if (RD_WR_ACCESS_TYPE == c_ACCESS_READ_OLD) begin : g_read_old_illegal
    $fatal(1, "ram_rd_arbiter: READ_OLD access type is not supported");
  end else if ((RD_WR_ACCESS_TYPE != c_ACCESS_CONFLICT) &&
               (RD_WR_ACCESS_TYPE != c_ACCESS_READ_NEW)) begin : g_access_unknown
    $fatal(1, "ram_rd_arbiter: unknown RD_WR_ACCESS_TYPE");
  end else if ((NB_RD < 1) || (RAM_LATENCY < 1)) begin : g_bad_sizing
    $fatal(1, "ram_rd_arbiter: NB_RD and RAM_LATENCY must be >= 1");
  end

  logic [c_PW-1:0]    r_rr_ptr;
  logic [c_PW-1:0]    w_grant_idx;
  logic [c_PW-1:0]    w_cand;
  logic [c_PW-1:0]    w_next_ptr;
  logic [AW-1:0]      w_grant_add;
  logic [NB_RD-1:0]   w_grant_oh;
  logic [NB_RD-1:0]   w_rdy;
  logic               w_any;
  logic               w_coll;
  logic               w_stall;
  logic               w_fire;
  logic               w_fwd;

  logic [RAM_LATENCY-1:0] r_pipe_vld;
  logic [RAM_LATENCY-1:0] r_pipe_fwd;
  logic [NB_RD-1:0]       r_pipe_id   [RAM_LATENCY];
  logic [WIDTH-1:0]       r_pipe_data [RAM_LATENCY];

  // Scan from farthest to nearest so the requester closest to rr_ptr wins.
  always_comb begin
    w_grant_idx = r_rr_ptr;
    w_cand      = '0;
    for (int k = NB_RD - 1; k >= 0; k--) begin
      w_cand = c_PW'((int'(r_rr_ptr) + k) % NB_RD);
      if (rd_req_vld[w_cand]) begin
        w_grant_idx = w_cand;
      end
    end
  end

  assign w_any       = |rd_req_vld;
  assign w_grant_add = rd_req_add[w_grant_idx*AW +: AW];
  assign w_grant_oh  = NB_RD'(1) << w_grant_idx;
  assign w_coll      = wr_en & (w_grant_add == wr_add);
  assign w_stall     = (RD_WR_ACCESS_TYPE == c_ACCESS_CONFLICT) & w_coll;
  assign w_fwd       = (RD_WR_ACCESS_TYPE == c_ACCESS_READ_NEW) & w_coll;
  assign w_fire      = a_rst_n & w_any & ~w_stall;
  assign w_rdy       = w_fire ? w_grant_oh : '0;
  assign w_next_ptr  = (w_grant_idx == c_PW'(NB_RD - 1)) ? '0 : w_grant_idx + 1'b1;

  assign rd_req_rdy  = w_rdy;
  assign ram_rd_en   = w_fire;
  assign ram_rd_add  = w_grant_add;
  assign ram_wr_en   = wr_en & a_rst_n;
  assign ram_wr_add  = wr_add;
  assign ram_wr_data = wr_data;

  always_ff @(posedge clk or negedge a_rst_n) begin
    if (!a_rst_n) begin
      r_rr_ptr   <= '0;
      r_pipe_vld <= '0;
      r_pipe_fwd <= '0;
      for (int k = 0; k < RAM_LATENCY; k++) begin
        r_pipe_id[k] <= '0;
      end
    end else begin
      if (w_fire) begin
        r_rr_ptr <= w_next_ptr;
      end
      r_pipe_vld[0] <= w_fire;
      r_pipe_fwd[0] <= w_fire & w_fwd;
      r_pipe_id[0]  <= w_rdy;
      for (int k = 1; k < RAM_LATENCY; k++) begin
        r_pipe_vld[k] <= r_pipe_vld[k-1];
        r_pipe_fwd[k] <= r_pipe_fwd[k-1];
        r_pipe_id[k]  <= r_pipe_id[k-1];
      end
    end
  end

  // Forwarded data is qualified by r_pipe_fwd, so it needs no reset.
  always_ff @(posedge clk) begin
    if (w_fire & w_fwd) begin
      r_pipe_data[0] <= wr_data;
    end
    for (int k = 1; k < RAM_LATENCY; k++) begin
      r_pipe_data[k] <= r_pipe_data[k-1];
    end
  end

  assign rd_data_vld = r_pipe_id[RAM_LATENCY-1] & {NB_RD{r_pipe_vld[RAM_LATENCY-1]}};
  assign rd_data     = r_pipe_fwd[RAM_LATENCY-1] ? r_pipe_data[RAM_LATENCY-1] : ram_rd_data;

endmodule
`default_nettype wire

// File: doc/ram_rd_arbiter.md
Name: ram_rd_arbiter

Overview:
- Shares the read port of one 1R1W RAM (ram_wrapper instance) between NB_RD read requesters using round-robin arbitration.
- Write traffic from a single writer always has priority and is never backpressured.
- The RAM behind this block is configured as conflict-type. The block ensures requesters never see a same-cycle read/write collision, using the policy selected by RD_WR_ACCESS_TYPE (ram_wrapper_pkg encoding).

Parameters:
- WIDTH, 32, data width.
- DEPTH, 1024, RAM words. AW = $clog2(DEPTH).
- NB_RD, 2, number of read requesters (>=1).
- RAM_LATENCY, 1, cycles from ram_rd_en to valid ram_rd_data (>=1).
- RD_WR_ACCESS_TYPE, RD_WR_ACCESS_TYPE_CONFLICT, collision policy.
  - CONFLICT: stall the read.
  - READ_NEW: forward the write data.
  - READ_OLD: illegal; $fatal at elaboration.

Ports:
- clk  in  1  clock
- a_rst_n  in  1  asynchronous active-low reset
- wr_en  in  1  write strobe
- wr_add  in  AW  write address
- wr_data  in  WIDTH  write data
- rd_req_vld  in  NB_RD  per-requester read request valid
- rd_req_rdy  out  NB_RD  per-requester accept
- rd_req_add  in  NB_RD*AW  per-requester address; requester i occupies bits [i*AW +: AW]
- rd_data_vld  out  NB_RD  one-hot return strobe; the set bit identifies the requester
- rd_data  out  WIDTH  shared return data
- ram_wr_en  out  1  to RAM
- ram_wr_add  out  AW  to RAM
- ram_wr_data  out  WIDTH  to RAM
- ram_rd_en  out  1  to RAM
- ram_rd_add  out  AW  to RAM
- ram_rd_data  in  WIDTH  from RAM, RAM_LATENCY cycles after ram_rd_en

Behaviour:
- Reset:
  - Asynchronous assert, active-low. rr_ptr=0; all return-pipeline valid bits=0.
  - While a_rst_n=0: rd_req_rdy=0, rd_data_vld=0, ram_rd_en=0, ram_wr_en=0.
- Write path (combinational pass-through):
  - ram_wr_en=wr_en & a_rst_n; ram_wr_add=wr_add; ram_wr_data=wr_data.
- Arbitration:
  - grant = first i with rd_req_vld[i]=1, searching cyclically from rr_ptr. Combinational, at most one grant per cycle.
  - ram_rd_add = rd_req_add of the granted requester.
- Collision: coll = wr_en & (granted address == wr_add).
- CONFLICT mode:
  - On coll=1: stall. rd_req_rdy=0 for all requesters, ram_rd_en=0, rr_ptr unchanged.
  - The same request wins the next cycle (if still valid and no new collision) and reads the new data.
- READ_NEW mode:
  - Never stalls.
  - On coll=1: ram_rd_en=1 as normal, but wr_data is captured into the return pipeline with fwd=1.
- Accept: rd_req_rdy[i] = grant[i] & ~stall. ready depends on vld; requesters must not make vld depend on rdy.
- Handshake (vld & rdy on the granted requester):
  - ram_rd_en=1.
  - rr_ptr <= (granted index+1) mod NB_RD.
  - Push {vld=1, id one-hot, fwd, fwd_data} into a RAM_LATENCY-stage shift register.
  - No handshake: push vld=0.
  - rr_ptr wraps NB_RD-1 -> 0.
- Return:
  - At the pipeline tail, rd_data_vld = id & {NB_RD{vld}}.
  - rd_data = fwd ? fwd_data : ram_rd_data.
  - Latency handshake -> rd_data_vld is exactly RAM_LATENCY cycles.
  - No return backpressure. Throughput is 1 read per cycle.
- No requests: ram_rd_en=0, rr_ptr holds.
- Only collisions in the same cycle are resolved. A write to the same address 1..RAM_LATENCY-1 cycles after a read is not a collision (the read returns old data).
- Reset mid-operation: in-flight reads are discarded and produce no rd_data_vld. The writer and requesters must reissue.

Test Plan:
- NB_RD=2, RAM_LATENCY=1, both vld, addrs 3 and 7, no writes -> grants alternate 0,1,0,1; rd_data_vld=01 then 10 one cycle after each handshake, with RAM contents of addrs 3 and 7.
- CONFLICT mode: wr_en=1 wr_add=5 wr_data=0xAA, same cycle req0 reads addr 5 -> rd_req_rdy=00 and ram_rd_en=0 that cycle; accepted next cycle; rd_data=0xAA; rr_ptr unchanged by the stall.
- READ_NEW, RAM_LATENCY=2: same collision -> accepted same cycle; rd_data=0xAA 2 cycles later while the bench drives ram_rd_data=0xDEAD.
- Write addr 6 while req1 reads addr 5 -> no stall; ram_rd_add=5; old data returned.
- Only req1 vld with rr_ptr=0 -> granted immediately; rr_ptr becomes 0 (wrap); req0 then wins priority next.
- RAM_LATENCY=3: two reads in flight, a_rst_n pulsed low 1 cycle -> no rd_data_vld afterwards, rr_ptr=0, all rdy=0 during reset.
